interleave_sequencer: RTL and testbench
=======================================

INTERLEAVE_SEQUENCER -- requirements
Module: interleave_sequencer

Interface
REQ-001 Parameter NUM_CH, default 32: number of physical ADC channels; fixes x_adc_select width at 5 bits.
REQ-002 Parameter FCNT_W, default 16: width of frame_count.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 GlobalReset  input  1  reset, asynchronous and active-low.
REQ-005 enable  input  1  level; 1 = run continuous frames, 0 = stop after the current frame.
REQ-006 oneshot  input  1  single-cycle pulse; runs exactly one frame when idle.
REQ-007 ch_last  input  5  index of last active channel (active channels 0..ch_last).
REQ-008 dwell  input  4  cycles per channel minus 1 (dwell+1 cycles per channel).
REQ-009 x_adc_select  output  5  channel select driven to the downstream 32:1 registered mux.
REQ-010 x_adc_valid  output  1  1 in the cycle the mux output holds a settled sample.
REQ-011 x_adc_ch  output  5  channel tag of the sample qualified by x_adc_valid.
REQ-012 frame_start  output  1  one-cycle pulse on the first RUN cycle of a frame.
REQ-013 frame_done  output  1  one-cycle pulse coincident with the last x_adc_valid of a frame.
REQ-014 frame_count  output  FCNT_W  number of completed frames, wraps modulo 2^FCNT_W.
REQ-015 busy  output  1  1 while state is not IDLE.

Function
REQ-016 States SHALL be IDLE, RUN and FINISH; IDLE is the reset state.
REQ-017 IDLE->RUN SHALL occur when enable=1 or oneshot=1; FINISH is entered from RUN when enable=0 or the frame was started by oneshot.
REQ-018 ch_last and dwell SHALL be captured into internal registers on the IDLE->RUN transition and at every frame wrap; changes mid-frame SHALL take no effect until the next frame.
REQ-019 On the first RUN cycle ch=0, dwell counter=0, frame_start=1.
REQ-020 In RUN/FINISH x_adc_select SHALL equal the current channel ch; in IDLE x_adc_select SHALL be 0.
REQ-021 The dwell counter SHALL count 0..dwell_q; the cycle where counter==dwell_q is the strobe cycle for ch.
REQ-022 After a strobe cycle ch SHALL increment and the dwell counter SHALL return to 0; if ch==ch_last_q, ch SHALL wrap to 0 (end of frame).
REQ-023 x_adc_valid and x_adc_ch SHALL be registered one cycle after the strobe cycle (x_adc_ch = strobed ch), matching the mux's 1-cycle latency.
REQ-024 frame_done SHALL assert with the x_adc_valid of channel ch_last_q; frame_count SHALL increment in the same cycle.
REQ-025 At end of frame: RUN with enable=1 and no oneshot origin SHALL continue in RUN with frame_start=1 on the next cycle (no gap cycle); otherwise go to IDLE.
REQ-026 FINISH SHALL behave as RUN but always return to IDLE at end of frame; re-asserting enable in FINISH SHALL return to RUN without aborting the frame.
REQ-027 oneshot while busy SHALL be ignored; enable and oneshot together in IDLE SHALL start continuous mode.
REQ-028 ch_last=0 SHALL repeat channel 0 every frame; dwell=0 SHALL strobe every cycle (frame of ch_last+1 cycles).
REQ-029 x_adc_valid SHALL never assert in IDLE except the delayed final sample in the first IDLE cycle.

Reset
REQ-030 GlobalReset=0 SHALL immediately force state=IDLE, ch=0, dwell counter=0, captured config=0, x_adc_select=0, x_adc_valid=0, x_adc_ch=0, frame_start=0, frame_done=0, frame_count=0, busy=0.
REQ-031 Reset mid-frame SHALL abort the frame with no frame_done and no frame_count increment; after release the block stays IDLE until enable/oneshot.

Verification
REQ-032 oneshot pulse, ch_last=3, dwell=0 -> select 0,1,2,3 on 4 consecutive cycles; valid with ch 0..3 one cycle later; frame_done with ch 3; frame_count=1; busy drops after.
REQ-033 enable=1, ch_last=31, dwell=2 -> each channel held 3 cycles; 96-cycle frames back-to-back with no gap; frame_start every 96 cycles.
REQ-034 enable dropped at ch 5 of a ch_last=7 frame -> frame completes to ch 7, frame_done=1, then IDLE; re-raising enable in FINISH keeps running.
REQ-035 ch_last changed 7->2 mid-frame -> current frame ends at ch 7; next frame ends at ch 2.
REQ-036 GlobalReset asserted mid-frame at ch 10 -> all outputs 0 asynchronously; frame_count unchanged from 0 after release; no valid until restart.
REQ-037 frame_count at 16'hFFFF with one more frame -> wraps to 0.

Source files
------------

// File: rtl/interleave_sequencer.sv
// Round-robin channel sequencer for a 32:1 registered ADC input mux.
// Steps through channels 0..ch_last, holding each for dwell+1 cycles, and
// flags the settled sample one cycle after each channel's strobe cycle.
module interleave_sequencer #(
  parameter int NUM_CH = 32,
  parameter int FCNT_W = 16
) (
  input  logic                       clk,
  input  logic                       GlobalReset,
  input  logic                       enable,
  input  logic                       oneshot,
  input  logic [$clog2(NUM_CH)-1:0]  ch_last,
  input  logic [3:0]                 dwell,
  output logic [$clog2(NUM_CH)-1:0]  x_adc_select,
  output logic                       x_adc_valid,
  output logic [$clog2(NUM_CH)-1:0]  x_adc_ch,
  output logic                       frame_start,
  output logic                       frame_done,
  output logic [FCNT_W-1:0]          frame_count,
  output logic                       busy
);

  localparam int CW = $clog2(NUM_CH);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     ch_q, ch_d;
  logic [3:0]        dcnt_q, dcnt_d;
  logic [CW-1:0]     chl_q, chl_d;
  logic [3:0]        dwl_q, dwl_d;
  logic              os_q, os_d;
  logic              first_q, first_d;
  logic              valid_q, valid_d;
  logic [CW-1:0]     vch_q, vch_d;
  logic              done_q, done_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  logic              running;
  logic              strobe;
  logic              eof;

  // Next-state: channel/dwell stepping, config capture and frame control
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    dcnt_d  = dcnt_q;
    chl_d   = chl_q;
    dwl_d   = dwl_q;
    os_d    = os_q;
    first_d = 1'b0;

    running = (state_q != IDLE);
    strobe  = running && (dcnt_q == dwl_q);
    eof     = strobe && (ch_q == chl_q);

    if (running) begin
      if (strobe) begin
        dcnt_d = '0;
        ch_d   = eof ? '0 : ch_q + CW'(1);
      end else begin
        dcnt_d = dcnt_q + 4'd1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (enable || oneshot) begin
          state_d = RUN;
          os_d    = !enable;
          chl_d   = ch_last;
          dwl_d   = dwell;
          ch_d    = '0;
          dcnt_d  = '0;
          first_d = 1'b1;
        end
      end
      RUN: begin
        if (eof) begin
          if (enable && !os_q) begin
            chl_d   = ch_last;
            dwl_d   = dwell;
            first_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (!enable || os_q) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        // Re-raised enable turns the frame back into continuous operation.
        if (eof) begin
          state_d = IDLE;
        end else if (enable) begin
          state_d = RUN;
          os_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    valid_d = strobe;
    vch_d   = strobe ? ch_q : vch_q;
    done_d  = eof;
    fcnt_d  = eof ? fcnt_q + FCNT_W'(1) : fcnt_q;
  end

  // Sequencer state registers
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      state_q <= IDLE;
      ch_q    <= '0;
      dcnt_q  <= '0;
      chl_q   <= '0;
      dwl_q   <= '0;
      os_q    <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      dcnt_q  <= dcnt_d;
      chl_q   <= chl_d;
      dwl_q   <= dwl_d;
      os_q    <= os_d;
      first_q <= first_d;
    end
  end

  // Sample qualification, delayed one cycle to line up with the mux output
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      valid_q <= 1'b0;
      vch_q   <= '0;
      done_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      valid_q <= valid_d;
      vch_q   <= vch_d;
      done_q  <= done_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign x_adc_select = busy ? ch_q : '0;
  assign x_adc_valid  = valid_q;
  assign x_adc_ch     = vch_q;
  assign frame_start  = first_q;
  assign frame_done   = done_q;
  assign frame_count  = fcnt_q;

endmodule

// File: tb/tb_interleave_sequencer.sv
// Scoreboard bench for interleave_sequencer: stimulus pushes expected samples,
// a negedge monitor pops and compares each qualified sample.
module tb_interleave_sequencer;

  logic        clk = 1'b0;
  logic        GlobalReset;
  logic        enable;
  logic        oneshot;
  logic [4:0]  ch_last;
  logic [3:0]  dwell;
  logic [4:0]  x_adc_select;
  logic        x_adc_valid;
  logic [4:0]  x_adc_ch;
  logic        frame_start;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        busy;

  typedef struct packed {
    logic [4:0]  ch;
    logic        done;
    logic [15:0] fc;
  } exp_t;

  exp_t        expq[$];
  logic [15:0] exp_fc;
  int          checks = 0;
  int          errors = 0;

  interleave_sequencer #(.NUM_CH(32), .FCNT_W(16)) dut (
    .clk          (clk),
    .GlobalReset  (GlobalReset),
    .enable       (enable),
    .oneshot      (oneshot),
    .ch_last      (ch_last),
    .dwell        (dwell),
    .x_adc_select (x_adc_select),
    .x_adc_valid  (x_adc_valid),
    .x_adc_ch     (x_adc_ch),
    .frame_start  (frame_start),
    .frame_done   (frame_done),
    .frame_count  (frame_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic push(input logic [4:0] ch, input logic done);
    exp_t e;
    if (done) exp_fc = exp_fc + 16'd1;
    e.ch   = ch;
    e.done = done;
    e.fc   = exp_fc;
    expq.push_back(e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sel"},   32'(x_adc_select), 0);
    chk({tag, "_valid"}, 32'(x_adc_valid),  0);
    chk({tag, "_ch"},    32'(x_adc_ch),     0);
    chk({tag, "_start"}, 32'(frame_start),  0);
    chk({tag, "_done"},  32'(frame_done),   0);
    chk({tag, "_count"}, 32'(frame_count),  0);
    chk({tag, "_busy"},  32'(busy),         0);
  endtask

  // Monitor: every qualified sample must match the next expected entry
  always @(negedge clk) begin
    if (x_adc_valid === 1'b1) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid got ch=%0d done=%0d count=%0d exp none",
                 x_adc_ch, frame_done, frame_count);
      end else begin
        exp_t e;
        e = expq.pop_front();
        if (x_adc_ch !== e.ch || frame_done !== e.done || frame_count !== e.fc) begin
          errors++;
          $display("FAIL sample got ch=%0d done=%0d count=%0d exp ch=%0d done=%0d count=%0d",
                   x_adc_ch, frame_done, frame_count, e.ch, e.done, e.fc);
        end
      end
    end else if (frame_done !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL done_without_valid got=%0d exp=0", frame_done);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    GlobalReset = 1'b0;
    enable      = 1'b0;
    oneshot     = 1'b0;
    ch_last     = '0;
    dwell       = '0;
    exp_fc      = '0;
    #3;
    chk_all_zero("reset");
    tick();
    GlobalReset = 1'b1;
    tick();

    // Oneshot frame, ch_last=3, dwell=0
    ch_last = 5'd3;
    dwell   = 4'd0;
    for (int c = 0; c < 4; c++) push(5'(c), c == 3);
    oneshot = 1'b1;
    tick();
    oneshot = 1'b0;
    for (int t = 0; t < 4; t++) begin
      chk("os_sel",   32'(x_adc_select), 32'(t));
      chk("os_start", 32'(frame_start),  32'(t == 0));
      chk("os_busy",  32'(busy),         1);
      tick();
    end
    chk("os_idle", 32'(busy), 0);
    chk("os_idle_sel", 32'(x_adc_select), 0);
    tick();

    // Continuous, ch_last=31, dwell=2: 96-cycle frames back to back
    ch_last = 5'd31;
    dwell   = 4'd2;
    for (int f = 0; f < 3; f++)
      for (int c = 0; c < 32; c++) push(5'(c), c == 31);
    enable = 1'b1;
    tick();
    for (int t = 0; t < 288; t++) begin
      chk("cont_sel",   32'(x_adc_select), 32'((t % 96) / 3));
      chk("cont_start", 32'(frame_start),  32'((t % 96) == 0));
      oneshot = (t == 50);
      if (t == 200) enable = 1'b0;
      tick();
    end
    oneshot = 1'b0;
    chk("cont_idle", 32'(busy), 0);
    tick();

    // Enable dropped at ch5 of ch_last=7, re-raised in FINISH
    ch_last = 5'd7;
    dwell   = 4'd0;
    for (int f = 0; f < 2; f++)
      for (int c = 0; c < 8; c++) push(5'(c), c == 7);
    enable = 1'b1;
    tick();
    for (int t = 0; t < 16; t++) begin
      chk("fin_sel",   32'(x_adc_select), 32'(t % 8));
      chk("fin_start", 32'(frame_start),  32'((t % 8) == 0));
      chk("fin_busy",  32'(busy),         1);
      if (t == 5 || t == 13) enable = 1'b0;
      if (t == 6) enable = 1'b1;
      tick();
    end
    chk("fin_idle", 32'(busy), 0);
    tick();

    // ch_last changed 7->2 mid-frame
    ch_last = 5'd7;
    for (int c = 0; c < 8; c++) push(5'(c), c == 7);
    for (int c = 0; c < 3; c++) push(5'(c), c == 2);
    enable = 1'b1;
    tick();
    for (int t = 0; t < 11; t++) begin
      chk("cfg_sel", 32'(x_adc_select), (t < 8) ? 32'(t) : 32'(t - 8));
      if (t == 3) ch_last = 5'd2;
      if (t == 8) enable = 1'b0;
      tick();
    end
    chk("cfg_idle", 32'(busy), 0);
    tick();

    // Reset mid-frame at ch10 (ch9's sample is wiped before it is sampled)
    ch_last = 5'd31;
    for (int c = 0; c < 9; c++) push(5'(c), 1'b0);
    enable = 1'b1;
    tick();
    for (int t = 0; t < 10; t++) begin
      chk("rst_sel", 32'(x_adc_select), 32'(t));
      tick();
    end
    chk("rst_pre_sel", 32'(x_adc_select), 10);
    #1;
    GlobalReset = 1'b0;
    #1;
    chk_all_zero("midrst");
    enable = 1'b0;
    exp_fc = '0;
    tick();
    GlobalReset = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("post_rst_busy",  32'(busy),        0);
      chk("post_rst_valid", 32'(x_adc_valid), 0);
      chk("post_rst_count", 32'(frame_count), 0);
    end
    chk("rst_queue", 32'(expq.size()), 0);

    // frame_count wrap: 65536 one-cycle frames of channel 0
    ch_last = 5'd0;
    dwell   = 4'd0;
    for (int n = 0; n < 65536; n++) push(5'd0, 1'b1);
    enable = 1'b1;
    tick();
    for (int i = 0; i < 65536; i++) begin
      if (i == 65535) enable = 1'b0;
      tick();
    end
    chk("wrap_count", 32'(frame_count), 0);
    chk("wrap_idle",  32'(busy),        0);
    tick();
    tick();
    chk("final_queue", 32'(expq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
